// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Sequential fixed-point neuron: result = act(sum(w[i]*x[i]) + bias).
//   LANES products are accumulated per clock. The result is saturated to
//   WORD_W bits.
//   Operands are captured on a start handshake, and the result is returned on
//   an output handshake.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous reset, active-high
//   start_valid_i  : operands valid
//   start_ready_o  : block is idle and can accept operands
//   weights_i      : N_INPUTS signed weights, packed [N_INPUTS-1:0][WORD_W-1:0]
//   x_i            : N_INPUTS signed inputs, same packing
//   bias_i         : signed bias, same Q format as the operands
//   act_mode_i     : 00 linear, 01 ReLU, 10 leaky (neg >>> 3), 11 linear
//   result_valid_o : result_o holds a finished result
//   result_ready_i : consumer accepts the result
//   result_o       : saturated, activated result
//   busy_o         : an operation is in flight (state != IDLE)
module neuron_mac_seq #(
  parameter int N_INPUTS = 16,
  parameter int WORD_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int LANES    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_valid_i,
  output logic                             start_ready_o,
  input  logic [N_INPUTS-1:0][WORD_W-1:0]  weights_i,
  input  logic [N_INPUTS-1:0][WORD_W-1:0]  x_i,
  input  logic [WORD_W-1:0]                bias_i,
  input  logic [1:0]                       act_mode_i,
  output logic                             result_valid_o,
  input  logic                             result_ready_i,
  output logic [WORD_W-1:0]                result_o,
  output logic                             busy_o
);

  localparam int ACC_W = 2*WORD_W + $clog2(N_INPUTS) + 1;
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WORD_W+1){1'b0}}, {(WORD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [N_INPUTS-1:0][WORD_W-1:0]  w_q, w_d;
  logic [N_INPUTS-1:0][WORD_W-1:0]  x_q, x_d;
  logic [1:0]                       mode_q, mode_d;
  logic [WORD_W-1:0]                res_q, res_d;
  logic                             vld_q, vld_d;

  logic signed [ACC_W-1:0]          lane_sum;
  logic signed [ACC_W-1:0]          bias_ext;

  // ReLU / leaky activation on the integer-aligned accumulator value.
  function automatic logic signed [ACC_W-1:0] activate(
    input logic signed [ACC_W-1:0] s,
    input logic [1:0]              mode
  );
    logic signed [ACC_W-1:0] r;
    case (mode)
      2'b01:   r = (s < 0) ? '0 : s;
      2'b10:   r = (s < 0) ? (s >>> 3) : s;
      default: r = s;
    endcase
    return r;
  endfunction

  // Clamp to the signed WORD_W range.
  function automatic logic [WORD_W-1:0] saturate(
    input logic signed [ACC_W-1:0] v
  );
    logic [WORD_W-1:0] r;
    if (v > SAT_MAX)      r = {1'b0, {(WORD_W-1){1'b1}}};
    else if (v < SAT_MIN) r = {1'b1, {(WORD_W-1){1'b0}}};
    else                  r = v[WORD_W-1:0];
    return r;
  endfunction

  // Sum of the LANES full-precision products selected by idx_q.
  always_comb begin
    logic signed [2*WORD_W-1:0] prod;
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      prod = $signed(w_q[idx_q + IDX_W'(j)]) * $signed(x_q[idx_q + IDX_W'(j)]);
      lane_sum = lane_sum + {{(ACC_W-2*WORD_W){prod[2*WORD_W-1]}}, prod};
    end
  end

  assign bias_ext = {{(ACC_W-WORD_W){bias_i[WORD_W-1]}}, bias_i};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    w_d     = w_q;
    x_d     = x_q;
    mode_d  = mode_q;
    res_d   = res_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid_i) begin
          w_d     = weights_i;
          x_d     = x_i;
          mode_d  = act_mode_i;
          acc_d   = bias_ext <<< FRAC_W;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + lane_sum;
        // idx returns to 0 on the last group so it never indexes past N_INPUTS.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_ACT;
        end else begin
          idx_d = idx_q + IDX_STEP;
        end
      end
      S_ACT: begin
        res_d   = saturate(activate(acc_q >>> FRAC_W, mode_q));
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready_i) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      mode_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign start_ready_o  = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = vld_q;
  assign result_o       = res_q;

endmodule
